// File: rtl/inst_dispatch_pkg.sv
// Shared definitions for the instruction controllers: opcodes, field
// positions (as distances from the instruction MSB), layer config record
// and the PE target-mask helper.
package inst_dispatch_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_CALC = 2'b01,
    OP_SAVE = 2'b10,
    OP_CONF = 2'b11
  } op_e;

  // Field positions counted down from the MSB, so they hold for any INST_W.
  localparam int OP_OFF      = 0;   // 2-bit opcode
  localparam int TYPE_OFF    = 2;   // 4-bit layer type
  localparam int ID_OFF      = 6;   // ID_W-bit PE/group id
  localparam int POOL_OFF    = 6;   // pooling / depool flag
  localparam int RELU_OFF    = 7;   // relu flag
  localparam int IN_SEG_OFF  = 8;   // 4-bit input channel segments
  localparam int OUT_SEG_OFF = 12;  // 4-bit output channel segments
  localparam int IN_W_OFF    = 16;  // 8-bit input image width
  localparam int OUT_W_OFF   = 24;  // 8-bit output image width

  // Widest PE array the mask helper supports (PE_NUM must stay below this).
  localparam int MASK_MAX = 256;

  typedef struct packed {
    logic [3:0] layer_type;
    logic [3:0] in_ch_seg;
    logic [3:0] out_ch_seg;
    logic [7:0] in_img_width;
    logic [7:0] out_img_width;
    logic       pooling;
    logic       relu;
    logic       depool;
  } conf_t;

  // PEs addressed by an instruction: one PE in single mode, a group of
  // grp_size PEs otherwise. Bits at or above pe_num are always zero, so an
  // out-of-range id yields an empty mask rather than wrapping.
  function automatic logic [MASK_MAX-1:0] tgt_mask(input int id, input logic single,
                                                   input int grp_size, input int pe_num);
    logic [MASK_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX; i++) begin
      if (i >= pe_num) begin
        m[i] = 1'b0;
      end else if (single) begin
        m[i] = (i == id);
      end else begin
        m[i] = (i >= id * grp_size) && (i < id * grp_size + grp_size);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/inst_chan_out.sv
// One outbound instruction channel: holds valid and data from a load until
// the consumer accepts, and flags the accepting cycle with done_o.
module inst_chan_out #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         done_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign done_o  = valid_q & ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Next state: load wins, otherwise drop valid once the handshake completes.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (done_o) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Channel registers; reset discards any pending transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/inst_dispatch.sv
// Top-level instruction dispatcher: accepts one host instruction at a time,
// waits for the addressed PEs, then issues it to the DMA-in, PE or DMA-out
// channel (or applies it as layer config) and pulses ping-pong switches.
module inst_dispatch
  import inst_dispatch_pkg::*;
#(
  parameter int PE_NUM   = 32,
  parameter int INST_W   = 64,
  parameter int GRP_SIZE = 4,
  parameter int ID_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid_i,
  output logic              ins_ready_o,
  input  logic [INST_W-1:0] ins_i,
  output logic              working_o,
  output logic              ddr2pe_ins_valid_o,
  input  logic              ddr2pe_ins_ready_i,
  output logic [INST_W-1:0] ddr2pe_ins_o,
  output logic              pe_ins_valid_o,
  input  logic              pe_ins_ready_i,
  output logic [INST_W-1:0] pe_ins_o,
  output logic              pe2ddr_ins_valid_o,
  input  logic              pe2ddr_ins_ready_i,
  output logic [INST_W-1:0] pe2ddr_ins_o,
  output logic [3:0]        conf_layer_type_o,
  output logic [3:0]        conf_in_ch_seg_o,
  output logic [3:0]        conf_out_ch_seg_o,
  output logic [7:0]        conf_in_img_width_o,
  output logic [7:0]        conf_out_img_width_o,
  output logic              conf_pooling_o,
  output logic              conf_relu_o,
  output logic              conf_depool_o,
  output logic [PE_NUM-1:0] switch_d_o,
  output logic [PE_NUM-1:0] switch_p_o,
  output logic [PE_NUM-1:0] switch_i_o,
  output logic [PE_NUM-1:0] switch_a_o,
  output logic              switch_b_o,
  input  logic [PE_NUM-1:0] pe_done_i
);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_WAIT = 2'b01, ST_ISSUE = 2'b10} state_e;

  state_e              state_q, state_d;
  logic [INST_W-1:0]   ins_q, ins_d;
  logic [PE_NUM-1:0]   mask_q, mask_d;
  logic                dep_ok_q, dep_ok_d, dep_s;
  conf_t               conf_q, conf_d;
  logic [PE_NUM-1:0]   swd_q, swd_d, swp_q, swp_d, swi_q, swi_d, swa_q, swa_d;
  logic                swb_q, swb_d;
  logic                working_q, working_d;
  op_e                 op_in_s, op_q_s;
  logic                accept_s, issue_go_s, any_valid_s;
  logic                hs_ddr2pe_s, hs_pe_s, hs_pe2ddr_s;
  logic [3:0]          type_s;
  int                  id_s;
  logic [MASK_MAX-1:0] mask_full_s;
  logic                unused_mask_s;

  assign op_in_s     = op_e'(ins_i[INST_W-1-OP_OFF -: 2]);
  assign op_q_s      = op_e'(ins_q[INST_W-1-OP_OFF -: 2]);
  assign type_s      = ins_q[INST_W-1-TYPE_OFF -: 4];
  assign id_s        = int'(ins_i[INST_W-1-ID_OFF -: ID_W]);
  assign mask_full_s = tgt_mask(id_s, conf_q.layer_type[0], GRP_SIZE, PE_NUM);
  assign unused_mask_s = ^mask_full_s[MASK_MAX-1:PE_NUM];

  assign ins_ready_o = (state_q == ST_IDLE) & ~rst;
  assign accept_s    = ins_valid_i & ins_ready_o;
  assign issue_go_s  = (state_q == ST_WAIT) & dep_ok_q;
  assign any_valid_s = ddr2pe_ins_valid_o | pe_ins_valid_o | pe2ddr_ins_valid_o;

  inst_chan_out #(.W(INST_W)) u_ddr2pe (
    .clk(clk), .rst(rst), .load_i(issue_go_s & (op_q_s == OP_LOAD)), .data_i(ins_q),
    .ready_i(ddr2pe_ins_ready_i), .valid_o(ddr2pe_ins_valid_o), .data_o(ddr2pe_ins_o),
    .done_o(hs_ddr2pe_s));

  inst_chan_out #(.W(INST_W)) u_pe (
    .clk(clk), .rst(rst), .load_i(issue_go_s & (op_q_s == OP_CALC)), .data_i(ins_q),
    .ready_i(pe_ins_ready_i), .valid_o(pe_ins_valid_o), .data_o(pe_ins_o),
    .done_o(hs_pe_s));

  inst_chan_out #(.W(INST_W)) u_pe2ddr (
    .clk(clk), .rst(rst), .load_i(issue_go_s & (op_q_s == OP_SAVE)), .data_i(ins_q),
    .ready_i(pe2ddr_ins_ready_i), .valid_o(pe2ddr_ins_valid_o), .data_o(pe2ddr_ins_o),
    .done_o(hs_pe2ddr_s));

  // Instruction latch and target mask, captured on host acceptance.
  always_comb begin
    ins_d  = ins_q;
    mask_d = mask_q;
    if (accept_s) begin
      ins_d = ins_i;
      if (op_in_s == OP_CALC || op_in_s == OP_SAVE) begin
        mask_d = mask_full_s[PE_NUM-1:0];
      end else begin
        mask_d = '0;
      end
    end else begin
      ins_d = ins_q;
    end
  end

  // Dependency check, only meaningful (and only registered as true) in WAIT.
  always_comb begin
    dep_s = 1'b0;
    case (op_q_s)
      OP_CONF: dep_s = ~any_valid_s & (&pe_done_i);
      OP_LOAD: dep_s = 1'b1;
      default: dep_s = &(pe_done_i | ~mask_q);
    endcase
    dep_ok_d = (state_q == ST_WAIT) & dep_s;
  end

  // FSM next state: IDLE -> WAIT -> ISSUE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_s) state_d = ST_WAIT; else state_d = ST_IDLE;
      ST_WAIT:  if (dep_ok_q) state_d = ST_ISSUE; else state_d = ST_WAIT;
      ST_ISSUE: begin
        if (op_q_s == OP_CONF || hs_ddr2pe_s || hs_pe_s || hs_pe2ddr_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Layer config update when a CONF instruction reaches ISSUE.
  always_comb begin
    conf_d = conf_q;
    if (state_q == ST_ISSUE && op_q_s == OP_CONF) begin
      conf_d.layer_type    = type_s;
      conf_d.in_ch_seg     = ins_q[INST_W-1-IN_SEG_OFF -: 4];
      conf_d.out_ch_seg    = ins_q[INST_W-1-OUT_SEG_OFF -: 4];
      conf_d.in_img_width  = ins_q[INST_W-1-IN_W_OFF -: 8];
      conf_d.out_img_width = ins_q[INST_W-1-OUT_W_OFF -: 8];
      conf_d.pooling       = (type_s[3:2] == 2'b00) ? ins_q[INST_W-1-POOL_OFF] : 1'b0;
      conf_d.relu          = (type_s[3:2] == 2'b00) ? ins_q[INST_W-1-RELU_OFF] : 1'b0;
      conf_d.depool        = (type_s[3:2] != 2'b00) ? ins_q[INST_W-1-POOL_OFF] : 1'b0;
    end else begin
      conf_d = conf_q;
    end
  end

  // Ping-pong strobes for the cycle after a PE or save handshake.
  always_comb begin
    swd_d = '0;
    swp_d = '0;
    swi_d = '0;
    swa_d = '0;
    swb_d = 1'b0;
    if (hs_pe_s) begin
      swd_d = mask_q;
      swp_d = mask_q;
      swi_d = mask_q;
      swa_d = (conf_q.layer_type[2:1] == 2'b10) ? mask_q : '0;
    end else if (hs_pe2ddr_s) begin
      swa_d = mask_q;
      swb_d = (conf_q.layer_type[2:1] == 2'b10) & ins_q[INST_W-1-TYPE_OFF-3];
    end else begin
      swb_d = 1'b0;
    end
    working_d = (state_q != ST_IDLE) | ins_valid_i | any_valid_s | ~(&pe_done_i);
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ins_q     <= '0;
      mask_q    <= '0;
      dep_ok_q  <= 1'b0;
      conf_q    <= '0;
      swd_q     <= '0;
      swp_q     <= '0;
      swi_q     <= '0;
      swa_q     <= '0;
      swb_q     <= 1'b0;
      working_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ins_q     <= ins_d;
      mask_q    <= mask_d;
      dep_ok_q  <= dep_ok_d;
      conf_q    <= conf_d;
      swd_q     <= swd_d;
      swp_q     <= swp_d;
      swi_q     <= swi_d;
      swa_q     <= swa_d;
      swb_q     <= swb_d;
      working_q <= working_d;
    end
  end

  assign working_o            = working_q;
  assign conf_layer_type_o    = conf_q.layer_type;
  assign conf_in_ch_seg_o     = conf_q.in_ch_seg;
  assign conf_out_ch_seg_o    = conf_q.out_ch_seg;
  assign conf_in_img_width_o  = conf_q.in_img_width;
  assign conf_out_img_width_o = conf_q.out_img_width;
  assign conf_pooling_o       = conf_q.pooling;
  assign conf_relu_o          = conf_q.relu;
  assign conf_depool_o        = conf_q.depool;
  assign switch_d_o           = swd_q;
  assign switch_p_o           = swp_q;
  assign switch_i_o           = swi_q;
  assign switch_a_o           = swa_q;
  assign switch_b_o           = swb_q;

endmodule
